// File: rtl/basic_cpu_pkg.sv
// basic_cpu_pkg
// Shared definitions for the basic accumulator computer sequencer:
//   - common-bus select codes (BUS_NONE..BUS_MEM)
//   - AC operation and E operation encodings
//   - run/stop state of the sequencer
//   - memory-reference opcodes (IR[14:12])
//   - bit positions of the register-reference micro-operations (IR[11:0])
package basic_cpu_pkg;

    localparam logic [2:0] BUS_NONE = 3'd0;
    localparam logic [2:0] BUS_AR   = 3'd1;
    localparam logic [2:0] BUS_PC   = 3'd2;
    localparam logic [2:0] BUS_DR   = 3'd3;
    localparam logic [2:0] BUS_AC   = 3'd4;
    localparam logic [2:0] BUS_IR   = 3'd5;
    localparam logic [2:0] BUS_TR   = 3'd6;
    localparam logic [2:0] BUS_MEM  = 3'd7;

    // NOP is zero so that an idle or reset sequencer drives an all-zero output word.
    typedef enum logic [3:0] {
        ALU_NOP  = 4'd0,
        ALU_AND  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_LDDR = 4'd3,
        ALU_CLR  = 4'd4,
        ALU_CMA  = 4'd5,
        ALU_CIR  = 4'd6,
        ALU_CIL  = 4'd7,
        ALU_INC  = 4'd8
    } alu_op_t;

    typedef enum logic [1:0] {
        E_NOP    = 2'd0,
        E_CLR    = 2'd1,
        E_CMP    = 2'd2,
        E_LDCOUT = 2'd3
    } e_op_t;

    typedef enum logic {
        SEQ_STOPPED = 1'b0,
        SEQ_RUNNING = 1'b1
    } run_state_t;

    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_IO  = 3'd7;

    localparam int RR_CLA = 11;
    localparam int RR_CLE = 10;
    localparam int RR_CMA = 9;
    localparam int RR_CME = 8;
    localparam int RR_CIR = 7;
    localparam int RR_CIL = 6;
    localparam int RR_INC = 5;
    localparam int RR_SPA = 4;
    localparam int RR_SNA = 3;
    localparam int RR_SZA = 2;
    localparam int RR_SZE = 1;
    localparam int RR_HLT = 0;

endpackage

// File: rtl/basic_cpu_sequencer_if.sv
// basic_cpu_sequencer_if
// Bundle between the sequencer and the datapath.
//   master: the sequencer (consumes IR/status/start, drives strobes and state)
//   slave : the datapath side (drives IR/status/start, consumes strobes)
interface basic_cpu_sequencer_if;
    import basic_cpu_pkg::*;

    logic        start;
    logic [15:0] ir;
    logic        ac_zero;
    logic        ac_sign;
    logic        e_flag;
    logic        dr_zero;

    logic [2:0]  s;
    logic        ar_ld, ar_inr, ar_clr;
    logic        pc_ld, pc_inr, pc_clr;
    logic        ir_ld, dr_ld, dr_inr;
    logic        ac_ld;
    alu_op_t     alu_op;
    e_op_t       e_op;
    logic        mem_rd, mem_wr;
    logic [2:0]  t;
    logic        running;

    modport master (
        input  start, ir, ac_zero, ac_sign, e_flag, dr_zero,
        output s, ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr,
               ir_ld, dr_ld, dr_inr, ac_ld, alu_op, e_op,
               mem_rd, mem_wr, t, running
    );

    modport slave (
        output start, ir, ac_zero, ac_sign, e_flag, dr_zero,
        input  s, ar_ld, ar_inr, ar_clr, pc_ld, pc_inr, pc_clr,
               ir_ld, dr_ld, dr_inr, ac_ld, alu_op, e_op,
               mem_rd, mem_wr, t, running
    );
endinterface

// File: rtl/basic_cpu_sequencer_seq_counter.sv
// seq_counter
// 3-bit sequence counter SC (T0..T6) with one-hot timing decode.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr_i        clear SC to 0 (wins over inr_i)
//   inr_i        advance SC by one
//   t_o          current count
//   t_hot_o      one-hot T0..T6
module seq_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       inr_i,
    output logic [2:0] t_o,
    output logic [6:0] t_hot_o
);
    logic [2:0] sc_q, sc_d;

    // Advancing past T6 folds back to T0 so SC can never reach 7.
    always_comb begin
        sc_d = sc_q;
        if (clr_i) begin
            sc_d = 3'd0;
        end else if (inr_i) begin
            sc_d = (sc_q >= 3'd6) ? 3'd0 : sc_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_q <= 3'd0;
        end else begin
            sc_q <= sc_d;
        end
    end

    always_comb begin
        t_hot_o = '0;
        for (int k = 0; k < 7; k++) begin
            t_hot_o[k] = (sc_q == 3'(k));
        end
    end

    assign t_o = sc_q;
endmodule

// File: rtl/basic_cpu_sequencer.sv
// basic_cpu_sequencer
// Timing-and-control unit of the basic accumulator computer. Holds the
// running flag, the I latch and the opcode latch D, and decodes every
// datapath strobe combinationally from those plus the SC timing signals.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         master side of basic_cpu_sequencer_if (start/IR/status in,
//               bus select, register/memory strobes, alu_op, e_op, t, running out)
module basic_cpu_sequencer
    import basic_cpu_pkg::*;
(
    input logic                   clk,
    input logic                   rst_n,
    basic_cpu_sequencer_if.master bus
);
    run_state_t run_q, run_d;
    logic       i_q, i_d;
    logic [2:0] d_q, d_d;
    logic       sc_clr, sc_inr;
    logic [2:0] sc_t;
    logic [6:0] t_hot;

    seq_counter u_seq_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (sc_clr),
        .inr_i   (sc_inr),
        .t_o     (sc_t),
        .t_hot_o (t_hot)
    );

    assign bus.t       = sc_t;
    assign bus.running = (run_q == SEQ_RUNNING);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= SEQ_STOPPED;
            i_q   <= 1'b0;
            d_q   <= 3'd0;
        end else begin
            run_q <= run_d;
            i_q   <= i_d;
            d_q   <= d_d;
        end
    end

    // Next state and all strobes. Every step ends with either sc_inr or
    // sc_clr so the instruction lengths fall out of where sc_clr is raised.
    always_comb begin
        run_d      = run_q;
        i_d        = i_q;
        d_d        = d_q;
        sc_clr     = 1'b0;
        sc_inr     = 1'b0;
        bus.s      = BUS_NONE;
        bus.ar_ld  = 1'b0;
        bus.ar_inr = 1'b0;
        bus.ar_clr = 1'b0;
        bus.pc_ld  = 1'b0;
        bus.pc_inr = 1'b0;
        bus.pc_clr = 1'b0;
        bus.ir_ld  = 1'b0;
        bus.dr_ld  = 1'b0;
        bus.dr_inr = 1'b0;
        bus.ac_ld  = 1'b0;
        bus.alu_op = ALU_NOP;
        bus.e_op   = E_NOP;
        bus.mem_rd = 1'b0;
        bus.mem_wr = 1'b0;

        if (run_q == SEQ_STOPPED) begin
            sc_clr = 1'b1;
            if (bus.start) begin
                run_d = SEQ_RUNNING;
            end
        end else if (t_hot[0]) begin
            bus.s     = BUS_PC;
            bus.ar_ld = 1'b1;
            sc_inr    = 1'b1;
        end else if (t_hot[1]) begin
            bus.s      = BUS_MEM;
            bus.mem_rd = 1'b1;
            bus.ir_ld  = 1'b1;
            bus.pc_inr = 1'b1;
            sc_inr     = 1'b1;
        end else if (t_hot[2]) begin
            bus.s     = BUS_IR;
            bus.ar_ld = 1'b1;
            i_d       = bus.ir[15];
            d_d       = bus.ir[14:12];
            sc_inr    = 1'b1;
        end else if (t_hot[3]) begin
            if (d_q == OP_IO) begin
                sc_clr = 1'b1;
                // I/O (I=1) is a no-op; register-reference executes from IR[11:0].
                if (!i_q) begin
                    if (bus.ir[RR_CLA])      bus.alu_op = ALU_CLR;
                    else if (bus.ir[RR_CMA]) bus.alu_op = ALU_CMA;
                    else if (bus.ir[RR_CIR]) bus.alu_op = ALU_CIR;
                    else if (bus.ir[RR_CIL]) bus.alu_op = ALU_CIL;
                    else if (bus.ir[RR_INC]) bus.alu_op = ALU_INC;
                    bus.ac_ld = bus.ir[RR_CLA] | bus.ir[RR_CMA] | bus.ir[RR_CIR] |
                                bus.ir[RR_CIL] | bus.ir[RR_INC];
                    if (bus.ir[RR_CLE])      bus.e_op = E_CLR;
                    else if (bus.ir[RR_CME]) bus.e_op = E_CMP;
                    bus.pc_inr = (bus.ir[RR_SPA] & !bus.ac_sign) |
                                 (bus.ir[RR_SNA] &  bus.ac_sign) |
                                 (bus.ir[RR_SZA] &  bus.ac_zero) |
                                 (bus.ir[RR_SZE] & !bus.e_flag);
                    if (bus.ir[RR_HLT]) begin
                        run_d = SEQ_STOPPED;
                    end
                end
            end else begin
                if (i_q) begin
                    bus.s      = BUS_MEM;
                    bus.mem_rd = 1'b1;
                    bus.ar_ld  = 1'b1;
                end
                sc_inr = 1'b1;
            end
        end else if (t_hot[4]) begin
            case (d_q)
                OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
                    bus.s      = BUS_MEM;
                    bus.mem_rd = 1'b1;
                    bus.dr_ld  = 1'b1;
                    sc_inr     = 1'b1;
                end
                OP_STA: begin
                    bus.s      = BUS_AC;
                    bus.mem_wr = 1'b1;
                    sc_clr     = 1'b1;
                end
                OP_BUN: begin
                    bus.s     = BUS_AR;
                    bus.pc_ld = 1'b1;
                    sc_clr    = 1'b1;
                end
                OP_BSA: begin
                    bus.s      = BUS_PC;
                    bus.mem_wr = 1'b1;
                    bus.ar_inr = 1'b1;
                    sc_inr     = 1'b1;
                end
                default: sc_clr = 1'b1;
            endcase
        end else if (t_hot[5]) begin
            case (d_q)
                OP_AND: begin
                    bus.ac_ld  = 1'b1;
                    bus.alu_op = ALU_AND;
                    sc_clr     = 1'b1;
                end
                OP_ADD: begin
                    bus.ac_ld  = 1'b1;
                    bus.alu_op = ALU_ADD;
                    bus.e_op   = E_LDCOUT;
                    sc_clr     = 1'b1;
                end
                OP_LDA: begin
                    bus.ac_ld  = 1'b1;
                    bus.alu_op = ALU_LDDR;
                    sc_clr     = 1'b1;
                end
                OP_BSA: begin
                    bus.s     = BUS_AR;
                    bus.pc_ld = 1'b1;
                    sc_clr    = 1'b1;
                end
                OP_ISZ: begin
                    bus.dr_inr = 1'b1;
                    sc_inr     = 1'b1;
                end
                default: sc_clr = 1'b1;
            endcase
        end else if (t_hot[6]) begin
            // Only ISZ legitimately reaches T6; anything else just recovers to T0.
            sc_clr = 1'b1;
            if (d_q == OP_ISZ) begin
                bus.s      = BUS_DR;
                bus.mem_wr = 1'b1;
                bus.pc_inr = bus.dr_zero;
            end
        end else begin
            sc_clr = 1'b1;
        end
    end
endmodule

// File: tb/tb_basic_cpu_sequencer.sv
// tb_basic_cpu_sequencer
// Directed and randomized checks of basic_cpu_sequencer against a
// per-instruction micro-operation table kept in the bench.
module tb_basic_cpu_sequencer;
    import basic_cpu_pkg::*;

    typedef struct packed {
        logic [2:0] s;
        logic       ar_ld, ar_inr, ar_clr;
        logic       pc_ld, pc_inr, pc_clr;
        logic       ir_ld, dr_ld, dr_inr;
        logic       ac_ld;
        logic [3:0] alu_op;
        logic [1:0] e_op;
        logic       mem_rd, mem_wr;
        logic [2:0] t;
        logic       running;
    } vec_t;

    logic clk;
    logic rst_n;
    int   vecCount  = 0;
    int   failCount = 0;

    basic_cpu_sequencer_if ifc ();

    basic_cpu_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic vec_t sampleDut();
        vec_t v;
        v.s       = ifc.s;
        v.ar_ld   = ifc.ar_ld;
        v.ar_inr  = ifc.ar_inr;
        v.ar_clr  = ifc.ar_clr;
        v.pc_ld   = ifc.pc_ld;
        v.pc_inr  = ifc.pc_inr;
        v.pc_clr  = ifc.pc_clr;
        v.ir_ld   = ifc.ir_ld;
        v.dr_ld   = ifc.dr_ld;
        v.dr_inr  = ifc.dr_inr;
        v.ac_ld   = ifc.ac_ld;
        v.alu_op  = ifc.alu_op;
        v.e_op    = ifc.e_op;
        v.mem_rd  = ifc.mem_rd;
        v.mem_wr  = ifc.mem_wr;
        v.t       = ifc.t;
        v.running = ifc.running;
        return v;
    endfunction

    function automatic int instrLen(logic [15:0] ir);
        case (ir[14:12])
            3'd7:       return 4;
            3'd3, 3'd4: return 5;
            3'd6:       return 7;
            default:    return 6;
        endcase
    endfunction

    function automatic bit isHalt(logic [15:0] ir);
        return ir[14:12] == 3'd7 && !ir[15] && ir[0];
    endfunction

    // Micro-operation table: expected outputs for cycle 'step' of instruction 'ir'.
    function automatic vec_t model(logic [15:0] ir, int step,
                                   logic az, logic asg, logic ef, logic dz);
        vec_t v = '0;
        logic [2:0] op = ir[14:12];
        v.t       = 3'(step);
        v.running = 1'b1;
        if (step == 0) begin
            v.s = 3'd2; v.ar_ld = 1;
        end else if (step == 1) begin
            v.s = 3'd7; v.mem_rd = 1; v.ir_ld = 1; v.pc_inr = 1;
        end else if (step == 2) begin
            v.s = 3'd5; v.ar_ld = 1;
        end else if (step == 3) begin
            if (op == 3'd7 && !ir[15]) begin
                v.alu_op = ir[11] ? ALU_CLR : ir[9] ? ALU_CMA : ir[7] ? ALU_CIR :
                           ir[6]  ? ALU_CIL : ir[5] ? ALU_INC : ALU_NOP;
                v.ac_ld  = (v.alu_op != ALU_NOP);
                v.e_op   = ir[10] ? E_CLR : ir[8] ? E_CMP : E_NOP;
                v.pc_inr = (ir[4] && !asg) || (ir[3] && asg) || (ir[2] && az) || (ir[1] && !ef);
            end else if (op != 3'd7 && ir[15]) begin
                v.s = 3'd7; v.mem_rd = 1; v.ar_ld = 1;
            end
        end else begin
            case (op)
                3'd0, 3'd1, 3'd2: begin
                    if (step == 4) begin
                        v.s = 3'd7; v.mem_rd = 1; v.dr_ld = 1;
                    end else begin
                        v.ac_ld  = 1;
                        v.alu_op = (op == 3'd0) ? ALU_AND : (op == 3'd1) ? ALU_ADD : ALU_LDDR;
                        v.e_op   = (op == 3'd1) ? E_LDCOUT : E_NOP;
                    end
                end
                3'd3: begin v.s = 3'd4; v.mem_wr = 1; end
                3'd4: begin v.s = 3'd1; v.pc_ld = 1; end
                3'd5: begin
                    if (step == 4) begin
                        v.s = 3'd2; v.mem_wr = 1; v.ar_inr = 1;
                    end else begin
                        v.s = 3'd1; v.pc_ld = 1;
                    end
                end
                default: begin
                    if (step == 4) begin
                        v.s = 3'd7; v.mem_rd = 1; v.dr_ld = 1;
                    end else if (step == 5) begin
                        v.dr_inr = 1;
                    end else begin
                        v.s = 3'd3; v.mem_wr = 1; v.pc_inr = dz;
                    end
                end
            endcase
        end
        return v;
    endfunction

    // Drives start and randomized status; forced values when drz/ef are 0 or 1.
    task automatic applyStimulus(input logic startBit, input int drz, input int ef);
        ifc.start   = startBit;
        ifc.ac_zero = 1'($urandom);
        ifc.ac_sign = 1'($urandom);
        ifc.e_flag  = (ef  >= 0) ? 1'(ef)  : 1'($urandom);
        ifc.dr_zero = (drz >= 0) ? 1'(drz) : 1'($urandom);
    endtask

    task automatic checkOutput(input string tag, input int step, input vec_t expected);
        vec_t got = sampleDut();
        vecCount++;
        assert (got === expected) else begin
            failCount++;
            $error("[TB] FAIL %s step %0d: got %h expected %h", tag, step, got, expected);
        end
    endtask

    // Runs one full instruction; called just after a rising edge with SC at T0.
    task automatic runInstr(input string tag, input logic [15:0] ir,
                            input logic [7:0] startMask, input int drz, input int ef);
        int len = instrLen(ir);
        ifc.ir = ir;
        for (int step = 0; step < len; step++) begin
            applyStimulus(startMask[step], drz, ef);
            @(negedge clk);
            checkOutput(tag, step,
                        model(ir, step, ifc.ac_zero, ifc.ac_sign, ifc.e_flag, ifc.dr_zero));
            @(posedge clk);
            #1;
        end
        ifc.start = 1'b0;
    endtask

    task automatic checkStopped(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            ifc.ir = 16'($urandom);
            applyStimulus(1'b0, -1, -1);
            @(negedge clk);
            checkOutput(tag, k, '0);
            @(posedge clk);
            #1;
        end
    endtask

    // Start pulse while stopped: outputs stay idle this cycle, T0 follows.
    task automatic startPulse();
        applyStimulus(1'b1, -1, -1);
        @(negedge clk);
        checkOutput("startCycle", 0, '0);
        @(posedge clk);
        #1;
        ifc.start = 1'b0;
    endtask

    initial begin
        logic [15:0] rir;
        rst_n       = 1'b0;
        ifc.start   = 1'b0;
        ifc.ir      = 16'h0000;
        ifc.ac_zero = 1'b0;
        ifc.ac_sign = 1'b0;
        ifc.e_flag  = 1'b0;
        ifc.dr_zero = 1'b0;
        #3;
        checkOutput("reset", 0, '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkStopped("idleAfterReset", 2);
        startPulse();

        runInstr("LDA", 16'h2005, 8'h00, -1, -1);
        runInstr("ADDind", 16'h9010, 8'h00, -1, -1);
        runInstr("ISZzero", 16'h6020, 8'h00, 1, -1);
        runInstr("ISZnonzero", 16'h6020, 8'h00, 0, -1);
        runInstr("CILSZE", 16'h7042, 8'h00, -1, 0);
        runInstr("HLT", 16'h7001, 8'h00, -1, -1);
        checkStopped("halted", 3);
        startPulse();
        runInstr("BSAstart", 16'h5030, 8'h10, -1, -1);
        runInstr("HLTstart", 16'h7021, 8'h08, -1, -1);
        checkStopped("haltedStart", 2);
        startPulse();

        // Reset arrives during STA T4 while mem_wr is high.
        ifc.ir = 16'h3040;
        for (int step = 0; step < 5; step++) begin
            applyStimulus(1'b0, -1, -1);
            @(negedge clk);
            checkOutput("STApreReset", step,
                        model(16'h3040, step, ifc.ac_zero, ifc.ac_sign, ifc.e_flag, ifc.dr_zero));
            if (step < 4) begin
                @(posedge clk);
                #1;
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("resetAbort", 0, '0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkStopped("afterAbort", 1);
        startPulse();

        for (int n = 0; n < 60; n++) begin
            rir = 16'($urandom);
            runInstr("random", rir, 8'($urandom & $urandom), -1, -1);
            if (isHalt(rir)) begin
                checkStopped("randomHalted", 2);
                startPulse();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, failCount);
        $finish;
    end
endmodule
